bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-ported, synchronous-read block RAM (BIOS/DMEM style, 32-bit words, 1-cycle read latency) between two CPU requesters: port 0 = instruction fetch, port 1 = data load/store.
- Performs per-cycle grant, drives the memory port, and routes the read data back to the owning requester.
- Returns a registered ack with held read data.
- Sits between the CPU pipeline and the memory wrapper; the CPU stalls on a missing grant.

Parameters:
- AWIDTH, 12, word-address width (4096 words)
- DWIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced (only used with ARB_ANTISTARVE_EN)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held with f_addr stable until f_gnt
- f_addr  in  AWIDTH  fetch word address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_ack  out  1  registered; pulses one cycle after f_gnt
- f_rdata  out  DWIDTH  fetch read data; valid with f_ack, held until next f_ack
- d_req  in  1  data request; held with address, data and mask stable until d_gnt
- d_addr  in  AWIDTH  data word address
- d_wdata  in  DWIDTH  store data
- d_wbe  in  DWIDTH/8  byte write enables; all-zero = load
- d_gnt  out  1  data granted this cycle (combinational)
- d_ack  out  1  registered; pulses one cycle after d_gnt (load or store)
- d_rdata  out  DWIDTH  load data; valid with d_ack after a load, held until the next load ack
- mem_en  out  1  memory enable
- mem_addr  out  AWIDTH  memory address
- mem_din  out  DWIDTH  memory write data
- mem_we  out  DWIDTH/8  memory byte write enables
- mem_dout  in  DWIDTH  memory read data, valid the cycle after mem_en

Behaviour:
- Grant (combinational, same cycle):
  - d_gnt = d_req & ~rst & ~force_f
  - f_gnt = f_req & ~rst & (~d_req | force_f)
  - Exactly one grant at most per cycle.
  - force_f = 0 when the optional feature is absent.
- Memory port:
  - mem_en = f_gnt | d_gnt
  - mem_addr, mem_din, mem_we are muxed from the granted port.
  - mem_we = 0 unless d_gnt.
  - mem_din = d_wdata, don't-care when mem_we = 0.
  - With no grant: mem_addr = 0, mem_we = 0.
- Tracking register:
  - `owner` records {valid, port, is_load} of the granted access.
- Ack, cycle N+1 after a grant at cycle N:
  - f_ack/d_ack = 1 for exactly one cycle.
  - f_rdata is captured from mem_dout into the hold register on a fetch ack.
  - d_rdata is captured only on a load ack (owner.is_load).
- Rdata hold: outputs are driven from the hold registers, so they stay stable until overwritten by the next read ack for that port.
- Back-to-back: a new grant may issue in cycle N+1 while the ack for cycle N is presented. Sustained throughput is 1 access/cycle.
- Simultaneous requests: data wins (older instruction in the pipeline); fetch waits.
- Reset:
  - While rst is high: gnt = 0 and mem_en = 0.
  - On the edge with rst high: f_ack, d_ack, owner.valid and the starve counter go to 0; f_rdata and d_rdata go to 0.
  - An access granted in the cycle before rst is asserted is dropped: no ack is produced after reset.
- Requester dropping req before grant is legal; no side effects.

Optional Feature:
- ARB_ANTISTARVE_EN defined:
  - A 3-bit (clog2(STARVE_LIMIT+1)) saturating counter increments each cycle f_req=1 & f_gnt=0.
  - It clears on f_gnt or when f_req=0.
  - When the counter == STARVE_LIMIT, force_f=1: fetch is granted over data for that cycle and d_req waits.
  - Counter clears on rst.
- Not defined: the counter does not exist, force_f=0, and data has strict priority (fetch can starve indefinitely).

Test Plan:
- Fetch only:
  - Stimulus: preload mem[0x010]=0xDEADBEEF; f_req=1, f_addr=0x010 at cycle 0.
  - Required: f_gnt=1 at cycle 0; f_ack=1 at cycle 1 with f_rdata=0xDEADBEEF; f_rdata still 0xDEADBEEF at cycle 5 with no further requests.
- Store then load:
  - Stimulus: d_req with d_addr=0x020, d_wdata=0x12345678, d_wbe=4'b0011; next cycle a load from 0x020.
  - Required: d_ack on both accesses; d_rdata=0x00005678 (prior contents 0).
- Contention:
  - Stimulus: f_req and d_req both asserted at cycle 0.
  - Required: d_gnt=1, f_gnt=0 at cycle 0; f_gnt=1 at cycle 1; d_ack at cycle 1; f_ack at cycle 2.
- Back-to-back fetches:
  - Stimulus: fetches of addresses 0, 1, 2, 3 on consecutive cycles.
  - Required: four consecutive f_ack cycles returning mem[0..3] in order.
- Reset mid-operation:
  - Stimulus: grant a load at cycle N; assert rst at cycle N+1 for 2 cycles.
  - Required: no d_ack after reset; d_rdata=0; mem_en=0 while rst is high.
- Starvation:
  - With ARB_ANTISTARVE_EN: d_req and f_req held high continuously → f_gnt=1 on cycle 4, counter cleared, d_gnt resumes on cycle 5.
  - Without the macro: f_gnt stays 0 for 20 cycles.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous-read BRAM port between instruction fetch (port 0) and data load/store (port 1).
// Data wins on contention; `define ARB_ANTISTARVE_EN to force a fetch grant after STARVE_LIMIT denied cycles.
module bram_port_arbiter #(
  parameter int AWIDTH       = 12,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [AWIDTH-1:0]     f_addr,
  output logic                  f_gnt,
  output logic                  f_ack,
  output logic [DWIDTH-1:0]     f_rdata,
  input  logic                  d_req,
  input  logic [AWIDTH-1:0]     d_addr,
  input  logic [DWIDTH-1:0]     d_wdata,
  input  logic [DWIDTH/8-1:0]   d_wbe,
  output logic                  d_gnt,
  output logic                  d_ack,
  output logic [DWIDTH-1:0]     d_rdata,
  output logic                  mem_en,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH-1:0]     mem_din,
  output logic [DWIDTH/8-1:0]   mem_we,
  input  logic [DWIDTH-1:0]     mem_dout
);

  localparam int BW = DWIDTH / 8;

  typedef struct packed {
    logic vld;
    logic port;     // 0 = fetch, 1 = data
    logic is_load;
  } owner_t;

  if ((DWIDTH % 8) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("bram_port_arbiter: DWIDTH must be a byte multiple and STARVE_LIMIT >= 1");
  end

  owner_t              r_owner;
  logic [DWIDTH-1:0]   r_f_hold;
  logic [DWIDTH-1:0]   r_d_hold;
  logic                w_force_f;
  logic                w_f_ack;
  logic                w_d_ack;
  logic                w_d_load_ack;

`ifdef ARB_ANTISTARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!f_req || f_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CW'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Gated with f_req so a stale count never blocks data when fetch has gone away.
  assign w_force_f = f_req & (r_starve_cnt == CW'(STARVE_LIMIT));
`else
  assign w_force_f = 1'b0;
`endif

  assign d_gnt  = d_req & ~rst & ~w_force_f;
  assign f_gnt  = f_req & ~rst & (~d_req | w_force_f);
  assign mem_en = f_gnt | d_gnt;

  always_comb begin
    mem_addr = '0;
    mem_we   = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_we   = d_wbe;
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  assign mem_din = d_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= '0;
    end else begin
      r_owner.vld     <= f_gnt | d_gnt;
      r_owner.port    <= d_gnt;
      r_owner.is_load <= d_gnt & ~(|d_wbe);
    end
  end

  // rst masks an ack still in flight from the cycle before reset.
  assign w_f_ack      = r_owner.vld & ~r_owner.port & ~rst;
  assign w_d_ack      = r_owner.vld &  r_owner.port & ~rst;
  assign w_d_load_ack = w_d_ack & r_owner.is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (w_f_ack)      r_f_hold <= mem_dout;
      if (w_d_load_ack) r_d_hold <= mem_dout;
    end
  end

  // mem_dout is only valid in the ack cycle, so bypass it there and hold afterwards.
  assign f_ack   = w_f_ack;
  assign d_ack   = w_d_ack;
  assign f_rdata = w_f_ack      ? mem_dout : r_f_hold;
  assign d_rdata = w_d_load_ack ? mem_dout : r_d_hold;

  logic [BW-1:0] w_unused_bw;
  assign w_unused_bw = '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first byte-writable BRAM model.
module tb_bram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, d_req;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wbe;
  logic          f_gnt, f_ack, d_gnt, d_ack, mem_en;
  logic [DW-1:0] f_rdata, d_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic          tb_init;
  logic [DW-1:0] mem [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wbe(d_wbe),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      for (int i = 0; i < 4; i++) mem[i] <= 32'h1111_0000 + i;
      mem[16]  <= 32'hDEAD_BEEF;
      mem_dout <= 32'h0;
    end else if (mem_en) begin
      mem_dout <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0;
    d_req = 1'b0;
    d_wbe = 4'b0;
  endtask

  logic [31:0] bb_exp [0:3];

  initial begin
    bb_exp[0] = 32'h1111_0000;
    bb_exp[1] = 32'h1111_0001;
    bb_exp[2] = 32'h1111_0002;
    bb_exp[3] = 32'h1111_0003;

    // reset with both requesters active
    rst = 1'b1; tb_init = 1'b1;
    f_req = 1'b1; d_req = 1'b1; f_addr = '0; d_addr = '0; d_wdata = '0; d_wbe = '0;
    next(); next(); settle();
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_f_ack", f_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    idle(); tb_init = 1'b0; rst = 1'b0;
    next();

    // fetch only
    f_req = 1'b1; f_addr = 12'h010; settle();
    chk("f1_gnt", f_gnt, 1);
    chk("f1_d_gnt", d_gnt, 0);
    chk("f1_mem_addr", mem_addr, 32'h010);
    chk("f1_mem_we", mem_we, 0);
    next(); f_req = 1'b0; settle();
    chk("f1_ack", f_ack, 1);
    chk("f1_rdata", f_rdata, 32'hDEAD_BEEF);
    chk("f1_mem_en_idle", mem_en, 0);
    chk("f1_mem_addr_idle", mem_addr, 0);
    next(); next(); next(); next(); settle();
    chk("f1_ack_gone", f_ack, 0);
    chk("f1_rdata_held", f_rdata, 32'hDEAD_BEEF);
    next();

    // store then load
    d_req = 1'b1; d_addr = 12'h020; d_wdata = 32'h1234_5678; d_wbe = 4'b0011; settle();
    chk("st_d_gnt", d_gnt, 1);
    chk("st_mem_we", mem_we, 32'h3);
    chk("st_mem_din", mem_din, 32'h1234_5678);
    next(); d_wbe = 4'b0000; settle();
    chk("st_ack", d_ack, 1);
    chk("st_rdata_untouched", d_rdata, 0);
    chk("ld_gnt", d_gnt, 1);
    chk("ld_mem_we", mem_we, 0);
    next(); idle(); settle();
    chk("ld_ack", d_ack, 1);
    chk("ld_rdata", d_rdata, 32'h0000_5678);
    next(); settle();
    chk("ld_ack_gone", d_ack, 0);
    chk("ld_rdata_held", d_rdata, 32'h0000_5678);
    next();

    // contention: data first, fetch next cycle
    f_req = 1'b1; f_addr = 12'h010; d_req = 1'b1; d_addr = 12'h020; d_wbe = 4'b0; settle();
    chk("ct0_d_gnt", d_gnt, 1);
    chk("ct0_f_gnt", f_gnt, 0);
    chk("ct0_mem_addr", mem_addr, 32'h020);
    next(); d_req = 1'b0; settle();
    chk("ct1_f_gnt", f_gnt, 1);
    chk("ct1_d_ack", d_ack, 1);
    chk("ct1_d_rdata", d_rdata, 32'h0000_5678);
    chk("ct1_f_ack", f_ack, 0);
    next(); idle(); settle();
    chk("ct2_f_ack", f_ack, 1);
    chk("ct2_d_ack", d_ack, 0);
    chk("ct2_f_rdata", f_rdata, 32'hDEAD_BEEF);
    next();

    // back-to-back fetches of 0..3
    for (int k = 0; k < 5; k++) begin
      f_req = (k < 4); f_addr = AW'(k); settle();
      if (k < 4) chk($sformatf("bb%0d_gnt", k), f_gnt, 1);
      if (k > 0) begin
        chk($sformatf("bb%0d_ack", k), f_ack, 1);
        chk($sformatf("bb%0d_rdata", k), f_rdata, bb_exp[k-1]);
      end
      next();
    end
    idle(); settle();
    chk("bb_ack_gone", f_ack, 0);
    chk("bb_rdata_held", f_rdata, 32'h1111_0003);
    next();

    // reset while a load is in flight
    d_req = 1'b1; d_addr = 12'h020; d_wbe = 4'b0; settle();
    chk("rm_gnt", d_gnt, 1);
    next(); d_req = 1'b0; rst = 1'b1; settle();
    chk("rm_ack_in_rst", d_ack, 0);
    chk("rm_mem_en_rst1", mem_en, 0);
    next(); d_req = 1'b1; f_req = 1'b1; settle();
    chk("rm_d_gnt_rst2", d_gnt, 0);
    chk("rm_f_gnt_rst2", f_gnt, 0);
    chk("rm_mem_en_rst2", mem_en, 0);
    chk("rm_d_rdata_clr", d_rdata, 0);
    chk("rm_f_rdata_clr", f_rdata, 0);
    next(); idle(); rst = 1'b0; settle();
    chk("rm_no_ack1", d_ack, 0);
    chk("rm_d_rdata_post", d_rdata, 0);
    next(); settle();
    chk("rm_no_ack2", d_ack, 0);
    chk("rm_no_f_ack2", f_ack, 0);
    next();

    // starvation with both requesters held
    f_req = 1'b1; f_addr = 12'h010; d_req = 1'b1; d_addr = 12'h020; d_wbe = 4'b0;
`ifdef ARB_ANTISTARVE_EN
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("sv%0d_f_gnt", k), f_gnt, (k == 4) ? 1 : 0);
      chk($sformatf("sv%0d_d_gnt", k), d_gnt, (k == 4) ? 0 : 1);
      next();
    end
`else
    for (int k = 0; k < 20; k++) begin
      settle();
      chk($sformatf("sv%0d_f_gnt", k), f_gnt, 0);
      chk($sformatf("sv%0d_d_gnt", k), d_gnt, 1);
      next();
    end
`endif
    idle();
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
